memx_sram: RTL and testbench
============================

Name: memx_sram

Overview:
- Multicycle single-port word memory that sits directly downstream of the memory-access controller.
- Accepts one read or write request at a time and drives the `busy_mem` handshake for a fixed, parameterised latency. The controller samples that handshake to sequence its `WAIT_READ` / `WAIT_WRITE` states.
- Returns read data with a one-cycle valid pulse and flags out-of-range addresses.

Parameters:
- RAM_ADDR_WIDTH, 8: width of the word address.
- RAM_N_OF_WORDS, 200: number of implemented words. Addresses >= this value are invalid. Must be <= 2**RAM_ADDR_WIDTH.
- DATA_WIDTH, 32: word width in bits.
- RD_LATENCY, 3: number of cycles `busy_mem_o` stays high for a read. Must be >= 1.
- WR_LATENCY, 4: number of cycles `busy_mem_o` stays high for a write. Must be >= 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous reset, active low.
- mem_rd_i  input  1  read request, sampled only in IDLE.
- mem_wr_i  input  1  write request, sampled only in IDLE.
- mem_addr_i  input  RAM_ADDR_WIDTH  word address, sampled together with the request.
- mem_wdata_i  input  DATA_WIDTH  write data, sampled together with the request.
- busy_mem_o  output  1  high while an accepted request is in progress.
- mem_rdata_o  output  DATA_WIDTH  last read data; held until the next completed read.
- mem_rvalid_o  output  1  one-cycle pulse: mem_rdata_o has just been updated.
- mem_err_o  output  1  one-cycle pulse: a request to an invalid address was rejected.

Behaviour:
- Reset values (asynchronous on rst_ni low):
  - state = IDLE, latency counter = 0.
  - busy_mem_o = 0, mem_rvalid_o = 0, mem_err_o = 0, mem_rdata_o = 0.
  - The storage array is not reset; its contents after reset are undefined.
- States:
  - IDLE: accepts requests.
  - BUSY_RD: a read is in progress.
  - BUSY_WR: a write is in progress.
- Acceptance in IDLE, for a request seen at edge T:
  - mem_wr_i=1: capture address and data, go to BUSY_WR. Write takes priority when both requests are high; the read is dropped, not queued.
  - mem_rd_i=1 (and mem_wr_i=0): capture address, go to BUSY_RD.
  - Invalid address (mem_addr_i >= RAM_N_OF_WORDS): stay in IDLE, mem_err_o=1 for cycle T+1 only. No busy, no storage change, mem_rdata_o unchanged.
  - No request: stay in IDLE.
- Busy timing, for a request accepted at edge T with LAT = RD_LATENCY or WR_LATENCY:
  - busy_mem_o=1 for exactly LAT cycles: T+1 through T+LAT.
  - busy_mem_o=0 from T+LAT+1. The state returns to IDLE at that same edge.
  - Counter loaded with LAT-1 at acceptance, decremented each busy cycle; exit when counter==0.
  - busy_mem_o is registered, not a combinational decode of the inputs.
- Completion:
  - Write: the storage word is updated at the final busy edge, so it is visible to a read accepted at T+LAT+1 or later.
  - Read: mem_rdata_o is loaded from storage at the final busy edge, and mem_rvalid_o=1 for cycle T+LAT+1 only.
- Requests while busy: mem_rd_i, mem_wr_i, mem_addr_i and mem_wdata_i are ignored. No error is raised and nothing is queued.
- Back-to-back: a request present in the first IDLE cycle after completion (T+LAT+1) is accepted at that edge. The minimum request-to-request spacing is therefore LAT+1 cycles.
- Reset mid-operation: the operation is aborted. An in-flight write is not committed; an in-flight read produces no rvalid pulse. busy_mem_o drops asynchronously.
- Address compare is unsigned, full RAM_ADDR_WIDTH. mem_err_o and mem_rvalid_o are never high in the same cycle.

Test Plan:
1. Reset release, then write addr 5 data 0xDEADBEEF with WR_LATENCY=4: busy_mem_o high for exactly 4 cycles, then low; no rvalid, no err.
2. Read addr 5 with RD_LATENCY=3: busy high for 3 cycles; in the following cycle mem_rvalid_o=1 and mem_rdata_o=0xDEADBEEF; rdata is held afterwards.
3. mem_rd_i and mem_wr_i high together, addr 7, data 0x12345678: write-length busy (4 cycles), no rvalid; a later read of addr 7 returns 0x12345678.
4. Read addr 200 (= RAM_N_OF_WORDS): mem_err_o pulses 1 cycle, busy stays 0, mem_rdata_o keeps its previous value.
5. Toggle mem_wr_i to addr 9 during a busy read, then read addr 9 after completion: the toggle is ignored, busy length is unchanged, and addr 9 keeps its prior content.
6. Assert rst_ni low at the second busy cycle of a write of 0xCAFEF00D to addr 3 (addr 3 previously 0x11111111): busy drops immediately and no rvalid; after release a read of addr 3 returns 0x11111111.

Source files
------------

// File: rtl/memx_sram.sv
// Multicycle single-port word memory: one request at a time, registered busy
// handshake for a fixed latency, one-cycle rvalid/err pulses.
module memx_sram #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_N_OF_WORDS = 200,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LATENCY     = 3,
    parameter int WR_LATENCY     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mem_rd_i,
    input  logic                      mem_wr_i,
    input  logic [RAM_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
    output logic                      busy_mem_o,
    output logic [DATA_WIDTH-1:0]     mem_rdata_o,
    output logic                      mem_rvalid_o,
    output logic                      mem_err_o
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [RAM_ADDR_WIDTH:0] N_WORDS = (RAM_ADDR_WIDTH+1)'(RAM_N_OF_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      accept, err_nxt, commit_rd, commit_wr, addr_ok;

    logic [DATA_WIDTH-1:0] mem [RAM_N_OF_WORDS];

    // Zero-extend so the compare stays unsigned even when N_WORDS == 2**AW.
    assign addr_ok = {1'b0, mem_addr_i} < N_WORDS;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        err_nxt   = 1'b0;
        commit_rd = 1'b0;
        commit_wr = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wr_i || mem_rd_i) begin
                    if (!addr_ok) begin
                        err_nxt = 1'b1;
                    end else if (mem_wr_i) begin
                        state_nxt = BUSY_WR;
                        cnt_nxt   = CNT_W'(WR_LATENCY - 1);
                        accept    = 1'b1;
                    end else begin
                        state_nxt = BUSY_RD;
                        cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                        accept    = 1'b1;
                    end
                end
            end
            BUSY_RD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    commit_rd = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            BUSY_WR: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    commit_wr = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_mem_o   <= 1'b0;
            mem_rvalid_o <= 1'b0;
            mem_err_o    <= 1'b0;
            mem_rdata_o  <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            busy_mem_o   <= (state_nxt != IDLE);
            mem_rvalid_o <= commit_rd;
            mem_err_o    <= err_nxt;
            if (accept) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
            end
            if (commit_rd) mem_rdata_o <= mem[addr_q];
        end
    end

    // Storage is deliberately not reset; a reset in flight leaves commit_wr low.
    always_ff @(posedge clk_i) begin
        if (commit_wr) mem[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_memx_sram.sv
// Directed bench for memx_sram: per-cycle expected outputs are queued when a
// request is issued and popped/compared on the falling edge.
module tb_memx_sram;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_rd_i, mem_wr_i;
    logic [7:0]  mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        busy_mem_o, mem_rvalid_o, mem_err_o;
    logic [31:0] mem_rdata_o;

    memx_sram dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mem_rd_i    (mem_rd_i),
        .mem_wr_i    (mem_wr_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .busy_mem_o  (busy_mem_o),
        .mem_rdata_o (mem_rdata_o),
        .mem_rvalid_o(mem_rvalid_o),
        .mem_err_o   (mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        busy;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [200];
    logic [31:0] model_rdata;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic b, input logic v, input logic e);
        exp_t x;
        x.tag = tag; x.busy = b; x.rvalid = v; x.err = e; x.rdata = model_rdata;
        sb.push_back(x);
    endtask

    // Called at a falling edge; request is accepted (or rejected) at the next rising edge.
    task automatic issue(input string tag, input logic rd, input logic wr,
                         input int addr, input logic [31:0] data);
        mem_rd_i    = rd;
        mem_wr_i    = wr;
        mem_addr_i  = 8'(addr);
        mem_wdata_i = data;
        if (addr >= 200) begin
            push(tag, 1'b0, 1'b0, 1'b1);
        end else if (wr) begin
            for (int i = 0; i < 4; i++) push(tag, 1'b1, 1'b0, 1'b0);
            model[addr] = data;
            push(tag, 1'b0, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < 3; i++) push(tag, 1'b1, 1'b0, 1'b0);
            model_rdata = model[addr];
            push(tag, 1'b0, 1'b1, 1'b0);
        end
        @(posedge clk_i);
        #1;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
    endtask

    // Pops one expectation per cycle; with noise, a write to addr 9 is toggled
    // while the DUT should still be busy.
    task automatic drain(input bit noise);
        exp_t x;
        while (sb.size() > 0) begin
            @(negedge clk_i);
            x = sb.pop_front();
            chk({x.tag, ".busy"},   32'(busy_mem_o),   32'(x.busy));
            chk({x.tag, ".rvalid"}, 32'(mem_rvalid_o), 32'(x.rvalid));
            chk({x.tag, ".err"},    32'(mem_err_o),    32'(x.err));
            chk({x.tag, ".rdata"},  mem_rdata_o,       x.rdata);
            if (noise && sb.size() > 0) begin
                mem_wr_i    = ~mem_wr_i;
                mem_addr_i  = 8'd9;
                mem_wdata_i = $urandom;
            end else begin
                mem_wr_i = 1'b0;
                mem_rd_i = 1'b0;
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; model_rdata = '0;
        repeat (3) @(negedge clk_i);
        chk("rst.busy",   32'(busy_mem_o),   32'd0);
        chk("rst.rvalid", 32'(mem_rvalid_o), 32'd0);
        chk("rst.err",    32'(mem_err_o),    32'd0);
        chk("rst.rdata",  mem_rdata_o,       32'd0);
        rst_ni = 1'b1;

        issue("wr5", 1'b0, 1'b1, 5, 32'hDEADBEEF); drain(0);
        issue("rd5", 1'b1, 1'b0, 5, 32'h0);        drain(0);
        push("hold5", 1'b0, 1'b0, 1'b0);           drain(0);

        issue("rdwr7", 1'b1, 1'b1, 7, 32'h12345678); drain(0);
        issue("rd7",   1'b1, 1'b0, 7, 32'h0);        drain(0);

        issue("rd200", 1'b1, 1'b0, 200, 32'h0);        drain(0);
        issue("wr255", 1'b0, 1'b1, 255, 32'hBADBAD00); drain(0);
        issue("wr199", 1'b0, 1'b1, 199, 32'h0BADF00D); drain(0);
        issue("rd199", 1'b1, 1'b0, 199, 32'h0);        drain(0);

        issue("wr9",    1'b0, 1'b1, 9, 32'hA5A5A5A5); drain(0);
        issue("rd9nz",  1'b1, 1'b0, 9, 32'h0);        drain(1);
        issue("rd9",    1'b1, 1'b0, 9, 32'h0);        drain(0);

        issue("wr3", 1'b0, 1'b1, 3, 32'h11111111); drain(0);
        // Abort a write of 0xCAFEF00D during its second busy cycle.
        mem_wr_i = 1'b1; mem_addr_i = 8'd3; mem_wdata_i = 32'hCAFEF00D;
        @(posedge clk_i); #1; mem_wr_i = 1'b0;
        @(negedge clk_i);
        chk("abort.busy1", 32'(busy_mem_o), 32'd1);
        @(negedge clk_i);
        chk("abort.busy2", 32'(busy_mem_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort.busy_async", 32'(busy_mem_o),   32'd0);
        chk("abort.rvalid",     32'(mem_rvalid_o), 32'd0);
        chk("abort.rdata",      mem_rdata_o,       32'd0);
        model_rdata = '0;
        repeat (2) @(negedge clk_i);
        chk("abort.busy_held", 32'(busy_mem_o),   32'd0);
        chk("abort.rvalid2",   32'(mem_rvalid_o), 32'd0);
        rst_ni = 1'b1;
        issue("rd3", 1'b1, 1'b0, 3, 32'h0); drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
